// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg
// Shared definitions for the MCP3204 SPI responder model:
//   - frame constants (control bit count, channel count)
//   - FSM state encoding
//   - differential subtract-and-clamp helper
package adc_spi_pkg;

    localparam int CMD_BITS = 4;   // SGL/DIFF, D2, D1, D0
    localparam int NUM_CH   = 4;

    // Frame-level state encoding. Kept as plain constants so older tools
    // and netlist viewers show stable, readable values.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_WAIT_START = 3'd1;
    localparam state_t ST_CMD        = 3'd2;
    localparam state_t ST_NULL       = 3'd3;
    localparam state_t ST_DATA       = 3'd4;
    localparam state_t ST_DONE       = 3'd5;

    // Working width of the subtract helper; DATA_W must not exceed this.
    localparam int CALC_W = 32;

    // minuend - subtrahend with one extra bit so a borrow shows up as a
    // sign bit; a negative difference becomes 0 rather than wrapping.
    function automatic logic [CALC_W-1:0] sub_clamp(
        input logic [CALC_W-1:0] minuend,
        input logic [CALC_W-1:0] subtrahend
    );
        logic [CALC_W:0] diff;
        diff = {1'b0, minuend} - {1'b0, subtrahend};
        return diff[CALC_W] ? '0 : diff[CALC_W-1:0];
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
// Brings the asynchronous SPI pins into the clk domain and derives
// single-cycle edge pulses for sclk and cs_n.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, cs_n, mosi    raw SPI pins (asynchronous)
//   cs_n_s, mosi_s      synchronized chip select / data
//   sclk_rise/fall      one-cycle pulses on synchronized sclk edges
//   cs_rise/fall        one-cycle pulses on synchronized cs_n edges
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2   // minimum 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_prev;
    logic                   cs_prev;

    // The cs_n chain resets to 0 on purpose: if cs_n is already low when
    // reset releases, no falling edge is seen, so the responder stays idle
    // until the controller deasserts and reasserts chip select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff   <= '0;
            cs_ff     <= '0;
            mosi_ff   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            cs_ff     <= {cs_ff[SYNC_STAGES-2:0], cs_n};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_ff[SYNC_STAGES-1];
            cs_prev   <= cs_ff[SYNC_STAGES-1];
        end
    end

    assign cs_n_s    = cs_ff[SYNC_STAGES-1];
    assign mosi_s    = mosi_ff[SYNC_STAGES-1];
    assign sclk_rise =  sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] &  sclk_prev;
    assign cs_rise   =  cs_ff[SYNC_STAGES-1]   & ~cs_prev;
    assign cs_fall   = ~cs_ff[SYNC_STAGES-1]   &  cs_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Behaves like an MCP3204 4-channel ADC on its SPI pins. Decodes the start
// bit and four control bits, then returns a null bit and a DATA_W-bit
// result (MSB first) taken from the parallel ch_data inputs.
// Ports:
//   clk, rst_n      50 MHz system clock, async active-low reset
//   sclk, cs_n, mosi  SPI pins from the controller (asynchronous)
//   ch_data         channel values, CHn at [n*DATA_W +: DATA_W]
//   miso, miso_oe   ADC data out and its output enable
//   cmd_valid       one-cycle pulse when D0 is captured
//   cmd_single      latched SGL/DIFF bit
//   cmd_chan        latched {D1,D0}
//   xfer_done       one-cycle pulse after B0 has been driven
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     mosi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     miso,
    output logic                     miso_oe,
    output logic                     cmd_valid,
    output logic                     cmd_single,
    output logic [1:0]               cmd_chan,
    output logic                     xfer_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = $clog2(CMD_BITS);

    logic cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall)
    );

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CMD_BITS-2:0]   cmd_sr;
    logic [IDX_W-1:0]      data_idx;
    logic [DATA_W-1:0]     result;

    logic                  rise_ok, fall_ok;
    logic [CMD_BITS-1:0]   cmd_word;
    logic [DATA_W-1:0]     ch [NUM_CH];
    logic [DATA_W-1:0]     pair_lo, pair_hi;
    logic [CALC_W-1:0]     diff_val;
    logic [DATA_W-1:0]     next_result;

    assign rise_ok  = sclk_rise & ~cs_n_s;
    assign fall_ok  = sclk_fall & ~cs_n_s;
    // On the D0 rise the full command is the three bits already shifted in
    // plus the bit currently on mosi: {SGL, D2, D1, D0}.
    assign cmd_word = {cmd_sr, mosi_s};

    // Result selection from the command being completed this cycle. It is
    // only registered on the D0 rise, so later ch_data changes are ignored.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch[i] = ch_data[i*DATA_W +: DATA_W];
        end
        pair_lo = ch[{cmd_word[1], 1'b0}];
        pair_hi = ch[{cmd_word[1], 1'b1}];
        if (cmd_word[0]) begin
            diff_val = sub_clamp(CALC_W'(pair_hi), CALC_W'(pair_lo));
        end else begin
            diff_val = sub_clamp(CALC_W'(pair_lo), CALC_W'(pair_hi));
        end
        if (cmd_word[3]) begin
            next_result = ch[cmd_word[1:0]];
        end else begin
            next_result = diff_val[DATA_W-1:0];
        end
    end

    // Frame FSM. A synchronized cs_n rise takes priority over everything,
    // including an sclk edge detected in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            cmd_valid  <= 1'b0;
            xfer_done  <= 1'b0;
            cmd_single <= 1'b0;
            cmd_chan   <= 2'b00;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            data_idx   <= '0;
            result     <= '0;
        end else begin
            cmd_valid <= 1'b0;
            xfer_done <= 1'b0;
            if (cs_rise) begin
                state   <= ST_IDLE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_WAIT_START;
                            miso    <= 1'b0;
                            miso_oe <= 1'b1;
                        end
                    end
                    ST_WAIT_START: begin
                        if (rise_ok && mosi_s) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (rise_ok) begin
                            cmd_sr <= cmd_word[CMD_BITS-2:0];
                            if (bit_cnt == CNT_W'(CMD_BITS-1)) begin
                                cmd_single <= cmd_word[3];
                                cmd_chan   <= cmd_word[1:0];
                                result     <= next_result;
                                cmd_valid  <= 1'b1;
                                state      <= ST_NULL;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_NULL: begin
                        if (fall_ok) begin
                            miso     <= 1'b0;
                            data_idx <= IDX_W'(DATA_W-1);
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (fall_ok) begin
                            miso <= result[data_idx];
                            if (data_idx == '0) begin
                                xfer_done <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                data_idx <= data_idx - 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (rise_ok || fall_ok) begin
                            miso <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI responder that models the MCP3204 4-channel 12-bit ADC on the MIKROE-340 board, so the FPGA-side ADC controller can be exercised and twinned without the physical converter. It oversamples the controller's chip select, SPI clock and MOSI with the 50 MHz system clock and decodes the start/control bits. It returns a null bit followed by a 12-bit MSB-first conversion result taken from parallel channel inputs. It sits between the ADC controller pins and a stimulus source (a pattern generator or fault-injection logic).

## Interface
- `DATA_W`, default 12: conversion result width.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs_n`, `mosi`; minimum 2.
- `clk`  in  1  50 MHz system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from the controller (asynchronous).
- `cs_n`  in  1  chip select, active low (asynchronous).
- `mosi`  in  1  controller-to-ADC data (asynchronous).
- `ch_data`  in  4*DATA_W  channel values; CHn occupies bits [n*DATA_W +: DATA_W].
- `miso`  out  1  ADC-to-controller data.
- `miso_oe`  out  1  high while `cs_n` is low (synchronized).
- `cmd_valid`  out  1  one-cycle pulse when D0 is captured.
- `cmd_single`  out  1  latched SGL/DIFF bit.
- `cmd_chan`  out  2  latched {D1,D0}.
- `xfer_done`  out  1  one-cycle pulse when B0 has been driven.

## Operation
- Edges: `sclk` rise/fall detected on synchronized samples (previous vs current). Data actions occur only on detected edges while synchronized `cs_n` = 0.
- States:
  - IDLE: `cs_n` high. Falling edge of synchronized `cs_n` -> WAIT_START.
  - WAIT_START: each `sclk` rise samples `mosi`; 0 stays here (leading zeros allowed); 1 -> CMD with bit count = 0.
  - CMD: four `sclk` rises capture SGL/DIFF, D2 (ignored), D1, D0 in that order. On the D0 rise: latch `cmd_single` and `cmd_chan`, compute and hold the result, pulse `cmd_valid`, -> NULL.
  - NULL: next `sclk` fall drives `miso` = 0 (null bit) -> DATA with bit index = DATA_W-1.
  - DATA: each subsequent `sclk` fall drives result[index] and decrements the index. After driving B0, pulse `xfer_done` -> DONE.
  - DONE: further `sclk` edges drive `miso` = 0 until `cs_n` rises.
- Synchronized `cs_n` rising in any state -> IDLE, `miso` = 0, no pulses, bit count cleared (abort).
- Result is computed once, at the D0 rise; `ch_data` changes afterwards do not affect the frame.
- Single-ended (SGL = 1): result = CH[cmd_chan].
- Differential (SGL = 0): pair = D1, and D0 selects polarity.
  - D0 = 0: CH(2p) − CH(2p+1).
  - D0 = 1: CH(2p+1) − CH(2p).
  - Compute with DATA_W+1 bits; a negative result clamps to 0, with no wrap.

## Timing
- Reset values: `miso` = 0, `miso_oe` = 0, `cmd_valid` = 0, `xfer_done` = 0, `cmd_single` = 0, `cmd_chan` = 0, state IDLE.
- Edge-to-action latency: SYNC_STAGES+1 `clk` cycles after the pin edge.
- Constraint: each `sclk` high and low phase lasts at least SYNC_STAGES+2 `clk` cycles. At the 50 kHz controller clock (500 cycles per phase) the margin is large.
- `miso` changes only after `sclk` falls, so it is stable at the controller's next `sclk` rise.
- Frame is start + 4 control bits + null + 12 data bits = 18 `sclk` cycles after the start-bit rise. A 20-count controller frame fits, and the trailing clocks return zeros.
- If a `cs_n` rise and an `sclk` edge are detected in the same cycle, `cs_n` wins: abort, and the edge is ignored.
- `rst_n` asserted mid-frame: all outputs return to their reset values immediately (asynchronous). After release, the block waits for a fresh `cs_n` falling edge, even if `cs_n` is already low.

## Structure
- Package `adc_spi_pkg` holds:
  - the state enum (IDLE, WAIT_START, CMD, NULL, DATA, DONE);
  - `CMD_BITS` = 4 and `NUM_CH` = 4;
  - a function for the differential subtract-and-clamp.
- Sub-module `spi_pin_sync`: a SYNC_STAGES flop chain per pin plus rise/fall pulse generation for `sclk` and `cs_n`. It is instantiated once for the three pins.

## Test plan
- Single-ended CH0: CH0 = 0xA5C, MOSI sequence 1,1,x,0,0, 20 `sclk` cycles at 50 kHz -> `cmd_valid` with chan 0, single 1. Sampled on rises: null 0, then 0xA5C MSB first; trailing bits 0.
- Differential clamp:
  - SGL = 0, D1 = 1, D0 = 0, CH2 = 0x100, CH3 = 0x300 -> result 0x000.
  - Same channels with D0 = 1 -> result 0x200.
- Leading zeros: three 0 bits before the start bit -> identical frame, shifted by three clocks.
- Abort: `cs_n` raised after 5 data bits -> `miso` = 0 and `miso_oe` = 0 within SYNC_STAGES+1 cycles, no `xfer_done`. The next frame decodes correctly.
- Async reset mid-data: `rst_n` low for 3 cycles -> all outputs at reset values immediately. Holding `cs_n` low afterwards produces no response until `cs_n` toggles.
- Channel hold: `ch_data` changed right after `cmd_valid` -> the shifted result equals the pre-change value.
